// File: rtl/pipeline_ctrl.sv
// Stall/flush/forward controller for the 5-stage RV32I pipeline.
// Gates register loads, latches early memory responses, counts stalls.
module pipeline_ctrl #(
  parameter int REG_W    = 5,
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_req,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  output logic             imem_en,
  output logic             dmem_en,
  input  logic [REG_W-1:0] ifid_rs1,
  input  logic [REG_W-1:0] ifid_rs2,
  input  logic [REG_W-1:0] idex_rs1,
  input  logic [REG_W-1:0] idex_rs2,
  input  logic [REG_W-1:0] idex_rd,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] exmem_rd,
  input  logic [REG_W-1:0] memwb_rd,
  input  logic             exmem_load_regfile,
  input  logic             memwb_load_regfile,
  input  logic             redirect,
  input  logic             counters_clr,
  output logic             load_pc,
  output logic             load_ifid,
  output logic             load_idex,
  output logic             load_exmem,
  output logic             load_memwb,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_timeout
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic              i_done;
  logic              d_done;
  logic [WAIT_W-1:0] wait_cnt;
  logic              i_ok;
  logic              d_ok;
  logic              advance;
  logic              lu;

  assign i_ok    = !imem_req | i_done | imem_resp;
  assign d_ok    = !dmem_req | d_done | dmem_resp;
  assign advance = i_ok & d_ok;
  assign lu      = idex_mem_read & (idex_rd != '0) &
                   ((idex_rd == ifid_rs1) | (idex_rd == ifid_rs2));

  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] rs
  );
    if (exmem_load_regfile && exmem_rd != '0 && exmem_rd == rs)
      return 2'b01;
    if (memwb_load_regfile && memwb_rd != '0 && memwb_rd == rs)
      return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    if (en && v != '1) return v + CNT_W'(1);
    return v;
  endfunction

  // Enables, flushes and selects; all held low while in reset.
  always_comb begin
    imem_en    = 1'b0;
    dmem_en    = 1'b0;
    load_pc    = 1'b0;
    load_ifid  = 1'b0;
    load_idex  = 1'b0;
    load_exmem = 1'b0;
    load_memwb = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    fwd_a_sel  = 2'b00;
    fwd_b_sel  = 2'b00;
    if (!rst) begin
      imem_en    = imem_req & !i_done;
      dmem_en    = dmem_req & !d_done;
      load_pc    = advance & (!lu | redirect);
      load_ifid  = advance & (!lu | redirect);
      load_idex  = advance;
      load_exmem = advance;
      load_memwb = advance;
      flush_ifid = advance & redirect;
      flush_idex = advance & (lu | redirect);
      fwd_a_sel  = fwd_sel(idex_rs1);
      fwd_b_sel  = fwd_sel(idex_rs2);
    end
  end

  // Remember responses that arrive before the other port is ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else if (advance) begin
      i_done <= 1'b0;
      d_done <= 1'b0;
    end else begin
      if (imem_resp) i_done <= 1'b1;
      if (dmem_resp) d_done <= 1'b1;
    end
  end

  // Saturating performance counters; clear beats increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else if (counters_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      stall_cnt  <= sat_inc(stall_cnt, !advance);
      bubble_cnt <= sat_inc(bubble_cnt, advance & lu & !redirect);
      flush_cnt  <= sat_inc(flush_cnt, advance & redirect);
    end
  end

  // Memory-wait watchdog; timeout is sticky until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (advance) begin
      wait_cnt <= '0;
    end else begin
      if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt == WAIT_LAST) mem_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl.
// Scoreboard of expected outputs, one task per scenario.
module tb_pipeline_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;
  localparam int MAXW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req, imem_resp, dmem_req, dmem_resp;
  logic imem_en, dmem_en;
  logic [REG_W-1:0] ifid_rs1, ifid_rs2;
  logic [REG_W-1:0] idex_rs1, idex_rs2, idex_rd;
  logic idex_mem_read;
  logic [REG_W-1:0] exmem_rd, memwb_rd;
  logic exmem_load_regfile, memwb_load_regfile;
  logic redirect, counters_clr;
  logic load_pc, load_ifid, load_idex, load_exmem, load_memwb;
  logic flush_ifid, flush_idex;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, flush_cnt;
  logic mem_timeout;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [8:0]       ctl;
    logic [3:0]       fwd;
    logic [CNT_W-1:0] st;
    logic [CNT_W-1:0] bu;
    logic [CNT_W-1:0] fl;
    logic             tmo;
  } exp_t;

  exp_t exp_q[$];

  logic m_idone, m_ddone, m_tmo;
  logic [CNT_W-1:0] m_stall, m_bubble, m_flush;
  int m_wait;

  pipeline_ctrl #(
    .REG_W(REG_W), .CNT_W(CNT_W), .MAX_WAIT(MAXW)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .imem_en(imem_en), .dmem_en(dmem_en),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_rs1(idex_rs1), .idex_rs2(idex_rs2),
    .idex_rd(idex_rd), .idex_mem_read(idex_mem_read),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_load_regfile(exmem_load_regfile),
    .memwb_load_regfile(memwb_load_regfile),
    .redirect(redirect), .counters_clr(counters_clr),
    .load_pc(load_pc), .load_ifid(load_ifid),
    .load_idex(load_idex), .load_exmem(load_exmem),
    .load_memwb(load_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] mfwd(input logic [REG_W-1:0] rs);
    if (exmem_load_regfile && exmem_rd != 0 && exmem_rd == rs) return 2'b01;
    if (memwb_load_regfile && memwb_rd != 0 && memwb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic clear_inputs();
    imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    ifid_rs1 = 0; ifid_rs2 = 0; idex_rs1 = 0; idex_rs2 = 0;
    idex_rd = 0; idex_mem_read = 0; exmem_rd = 0; memwb_rd = 0;
    exmem_load_regfile = 0; memwb_load_regfile = 0;
    redirect = 0; counters_clr = 0;
  endtask

  // Drive one cycle: predict, queue, compare at negedge, advance model.
  task automatic step(input string tag);
    exp_t e, g;
    logic adv, l;
    if (rst) begin
      m_idone = 0; m_ddone = 0; m_tmo = 0; m_wait = 0;
      m_stall = 0; m_bubble = 0; m_flush = 0;
    end
    adv = (!imem_req || m_idone || imem_resp) &&
          (!dmem_req || m_ddone || dmem_resp);
    l = idex_mem_read && idex_rd != 0 &&
        (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
    e.st = m_stall; e.bu = m_bubble; e.fl = m_flush; e.tmo = m_tmo;
    if (rst) begin
      e.ctl = '0; e.fwd = '0;
    end else begin
      e.ctl = {adv && (!l || redirect), adv && (!l || redirect),
               adv, adv, adv, adv && redirect, adv && (l || redirect),
               imem_req && !m_idone, dmem_req && !m_ddone};
      e.fwd = {mfwd(idex_rs1), mfwd(idex_rs2)};
    end
    exp_q.push_back(e);
    @(negedge clk);
    g = exp_q.pop_front();
    checks++;
    if ({load_pc, load_ifid, load_idex, load_exmem, load_memwb,
         flush_ifid, flush_idex, imem_en, dmem_en} !== g.ctl) begin
      errors++;
      $display("FAIL %s ctl got %b exp %b", tag,
        {load_pc, load_ifid, load_idex, load_exmem, load_memwb,
         flush_ifid, flush_idex, imem_en, dmem_en}, g.ctl);
    end
    checks++;
    if ({fwd_a_sel, fwd_b_sel} !== g.fwd) begin
      errors++;
      $display("FAIL %s fwd got %b exp %b", tag,
               {fwd_a_sel, fwd_b_sel}, g.fwd);
    end
    checks++;
    if ({stall_cnt, bubble_cnt, flush_cnt, mem_timeout} !==
        {g.st, g.bu, g.fl, g.tmo}) begin
      errors++;
      $display("FAIL %s cnt got %h/%h/%h/%b exp %h/%h/%h/%b", tag,
               stall_cnt, bubble_cnt, flush_cnt, mem_timeout,
               g.st, g.bu, g.fl, g.tmo);
    end
    if (!rst) begin
      if (adv) begin
        m_idone = 0; m_ddone = 0; m_wait = 0;
      end else begin
        if (imem_resp) m_idone = 1;
        if (dmem_resp) m_ddone = 1;
        if (m_wait < MAXW) m_wait++;
        if (m_wait == MAXW) m_tmo = 1;
      end
      if (counters_clr) begin
        m_stall = 0; m_bubble = 0; m_flush = 0;
      end else begin
        if (!adv && m_stall != '1) m_stall++;
        if (adv && l && !redirect && m_bubble != '1) m_bubble++;
        if (adv && redirect && m_flush != '1) m_flush++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clr_step();
    counters_clr = 1;
    step("clr");
    counters_clr = 0;
  endtask

  task automatic test_reset();
    imem_req = 1; dmem_req = 1; imem_resp = 1; dmem_resp = 1;
    redirect = 1; exmem_load_regfile = 1; exmem_rd = 3; idex_rs1 = 3;
    #1;
    checks++;
    if ({load_pc, load_ifid, load_idex, flush_ifid, flush_idex,
         imem_en, dmem_en, fwd_a_sel} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outs got %b exp 0",
        {load_pc, load_ifid, load_idex, flush_ifid, flush_idex,
         imem_en, dmem_en, fwd_a_sel});
    end
    step("reset");
    rst = 0;
    clear_inputs();
    step("reset_exit");
  endtask

  task automatic test_zero_wait();
    imem_req = 1; dmem_req = 1; imem_resp = 1; dmem_resp = 1;
    repeat (4) step("zero_wait");
    checks++;
    if (stall_cnt !== 0) begin
      errors++;
      $display("FAIL zero_wait_stall got %0d exp 0", stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_split();
    clr_step();
    step("split1");
    step("split2");
    imem_req = 1; dmem_req = 1; imem_resp = 1;
    #1;
    checks++;
    if (load_idex !== 0) begin
      errors++;
      $display("FAIL split3_adv got %b exp 0", load_idex);
    end
    step("split3");
    imem_resp = 0;
    for (int c = 4; c <= 6; c++) begin
      if (c == 6) dmem_resp = 1;
      #1;
      checks++;
      if (imem_en !== 0 || load_idex !== (c == 6)) begin
        errors++;
        $display("FAIL split%0d imem_en/adv got %b%b exp 0%b",
                 c, imem_en, load_idex, c == 6);
      end
      step("split");
    end
    checks++;
    if (stall_cnt !== 3) begin
      errors++;
      $display("FAIL split_stall got %0d exp 3", stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clr_step();
    imem_req = 1; dmem_req = 1; imem_resp = 1; dmem_resp = 1;
    idex_mem_read = 1; idex_rd = 5; ifid_rs1 = 5; ifid_rs2 = 1;
    #1;
    checks++;
    if (load_pc !== 0 || flush_idex !== 1) begin
      errors++;
      $display("FAIL lu_stall got pc=%b fl=%b exp pc=0 fl=1",
               load_pc, flush_idex);
    end
    step("lu");
    idex_mem_read = 0; idex_rd = 6; idex_rs1 = 5; idex_rs2 = 1;
    ifid_rs1 = 0; ifid_rs2 = 0;
    memwb_rd = 5; memwb_load_regfile = 1;
    #1;
    checks++;
    if (fwd_a_sel !== 2'b10) begin
      errors++;
      $display("FAIL lu_fwd got %b exp 10", fwd_a_sel);
    end
    step("lu_fwd");
    checks++;
    if (bubble_cnt !== 1) begin
      errors++;
      $display("FAIL lu_bubble got %0d exp 1", bubble_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_fwd_priority();
    exmem_rd = 7; memwb_rd = 7; idex_rs2 = 7;
    exmem_load_regfile = 1; memwb_load_regfile = 1;
    #1;
    checks++;
    if (fwd_b_sel !== 2'b01) begin
      errors++;
      $display("FAIL fwd_prio got %b exp 01", fwd_b_sel);
    end
    step("fwd_prio");
    exmem_rd = 0; memwb_rd = 0; idex_rs2 = 0;
    #1;
    checks++;
    if (fwd_b_sel !== 2'b00) begin
      errors++;
      $display("FAIL fwd_x0 got %b exp 00", fwd_b_sel);
    end
    step("fwd_x0");
    exmem_rd = 7; memwb_rd = 7; idex_rs2 = 7; exmem_load_regfile = 0;
    step("fwd_wb");
    clear_inputs();
  endtask

  task automatic test_redirect_lu();
    clr_step();
    imem_req = 1; dmem_req = 1; imem_resp = 1; dmem_resp = 1;
    idex_mem_read = 1; idex_rd = 9; ifid_rs2 = 9; redirect = 1;
    #1;
    checks++;
    if ({load_pc, flush_ifid, flush_idex} !== 3'b111) begin
      errors++;
      $display("FAIL redir_lu got %b exp 111",
               {load_pc, flush_ifid, flush_idex});
    end
    step("redir_lu");
    checks++;
    if (flush_cnt !== 1 || bubble_cnt !== 0) begin
      errors++;
      $display("FAIL redir_cnt got f=%0d b=%0d exp f=1 b=0",
               flush_cnt, bubble_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    clr_step();
    dmem_req = 1;
    repeat (7) step("wd");
    checks++;
    if (mem_timeout !== 0) begin
      errors++;
      $display("FAIL wd_early got %b exp 0", mem_timeout);
    end
    step("wd8");
    checks++;
    if (mem_timeout !== 1) begin
      errors++;
      $display("FAIL wd_fire got %b exp 1", mem_timeout);
    end
    dmem_resp = 1;
    step("wd_resp");
    dmem_req = 0; dmem_resp = 0;
    clr_step();
    checks++;
    if (mem_timeout !== 1 || stall_cnt !== 0) begin
      errors++;
      $display("FAIL wd_hold got t=%b s=%0d exp t=1 s=0",
               mem_timeout, stall_cnt);
    end
    rst = 1;
    step("wd_rst");
    checks++;
    if ({stall_cnt, bubble_cnt, flush_cnt, mem_timeout} !== '0) begin
      errors++;
      $display("FAIL wd_rst got %h exp 0",
               {stall_cnt, bubble_cnt, flush_cnt, mem_timeout});
    end
    rst = 0;
    step("wd_rst_exit");
  endtask

  task automatic test_saturation();
    clr_step();
    dmem_req = 1;
    repeat (20) step("sat");
    checks++;
    if (stall_cnt !== 4'hF) begin
      errors++;
      $display("FAIL sat got %0d exp 15", stall_cnt);
    end
    counters_clr = 1;
    step("sat_clr");
    checks++;
    if (stall_cnt !== 0) begin
      errors++;
      $display("FAIL sat_clr got %0d exp 0", stall_cnt);
    end
    rst = 1;
    step("sat_rst");
    rst = 0;
    clear_inputs();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      imem_req = 1'($urandom_range(0, 1));
      imem_resp = 1'($urandom_range(0, 1));
      dmem_req = 1'($urandom_range(0, 1));
      dmem_resp = 1'($urandom_range(0, 1));
      ifid_rs1 = 5'($urandom_range(0, 3));
      ifid_rs2 = 5'($urandom_range(0, 3));
      idex_rs1 = 5'($urandom_range(0, 3));
      idex_rs2 = 5'($urandom_range(0, 3));
      idex_rd = 5'($urandom_range(0, 3));
      idex_mem_read = 1'($urandom_range(0, 1));
      exmem_rd = 5'($urandom_range(0, 3));
      memwb_rd = 5'($urandom_range(0, 3));
      exmem_load_regfile = 1'($urandom_range(0, 1));
      memwb_load_regfile = 1'($urandom_range(0, 1));
      redirect = 1'($urandom_range(0, 3) == 0);
      counters_clr = 1'($urandom_range(0, 15) == 0);
      step("rand");
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    m_idone = 0; m_ddone = 0; m_tmo = 0; m_wait = 0;
    m_stall = 0; m_bubble = 0; m_flush = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_zero_wait();
    test_split();
    test_load_use();
    test_fwd_priority();
    test_redirect_lu();
    test_watchdog();
    test_saturation();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
